// File: rtl/avalon_mem_responder.sv
// Avalon-MM memory-mapped slave backed by a 2^MEM_AW x 32-bit memory.
// Reads return after a fixed READ_LAT, in order, with at most MAX_PEND
// reads outstanding. Define AVMM_RESP_WAITSTATE_EN to compile in a small
// FSM that stalls every command for WAIT_CYC cycles before accepting it.
//
// Handshake: a command is accepted at a rising edge where
// (avs_read | avs_write) = 1 and avs_waitrequest = 0. avs_readdatavalid
// is a one-cycle pulse with no backpressure from the master.
module avalon_mem_responder #(
  parameter int MEM_AW   = 10,
  parameter int READ_LAT = 2,
  parameter int MAX_PEND = 2,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [31:0] avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [3:0]  avs_byteenable,
  input  logic [31:0] avs_writedata,
  output logic        avs_waitrequest,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        err_sticky
);

  if (READ_LAT < 1 || READ_LAT > 4 || MAX_PEND < 1 || MAX_PEND > READ_LAT ||
      WAIT_CYC < 1 || WAIT_CYC > 7) begin : g_bad_param
    $error("avalon_mem_responder: parameter out of legal range");
  end

  localparam int DEPTH = 1 << MEM_AW;

  // Memory has no reset; its contents survive reset_reset_n.
  logic [31:0]       mem [DEPTH];
  logic [2:0]        pending;
  logic              full;
  logic              cmd;
  logic              accept;
  logic              rd_acc;
  logic              wr_acc;
  logic [MEM_AW-1:0] widx;
  logic [READ_LAT-1:0] pv;
  logic [31:0]       pd [READ_LAT];
  logic              ret;
  logic              unused_addr_bits;

  assign cmd    = avs_read | avs_write;
  assign accept = cmd & ~avs_waitrequest;
  // read+write together is treated as a write only
  assign rd_acc = accept & avs_read & ~avs_write;
  assign wr_acc = accept & avs_write;
  assign widx   = avs_address[MEM_AW+1:2];
  assign full   = (pending == 3'(MAX_PEND));
  // a read counts as returned once its valid cycle has ended
  assign ret    = pv[READ_LAT-1];
  assign unused_addr_bits = ^{avs_address[31:MEM_AW+2], avs_address[1:0]};

`ifdef AVMM_RESP_WAITSTATE_EN
  typedef enum logic [1:0] {S_IDLE, S_STALL, S_ACCEPT} ws_state_t;
  ws_state_t state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       stall;

  // Wait-state FSM register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: the IDLE cycle that sees a command is the first stall
  // cycle, STALL supplies the remaining WAIT_CYC-1, then ACCEPT waits
  // only on the pending limit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd) begin
          stall = 1'b1;
          if (WAIT_CYC == 1) begin
            state_nxt = S_ACCEPT;
          end else begin
            state_nxt = S_STALL;
            cnt_nxt   = 3'd1;
          end
        end
      end
      S_STALL: begin
        if (!cmd) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          stall = 1'b1;
          if (cnt == 3'(WAIT_CYC - 1)) begin
            state_nxt = S_ACCEPT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end
      end
      S_ACCEPT: begin
        if (!cmd || !full) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign avs_waitrequest = ~reset_reset_n | full | stall;
`else
  assign avs_waitrequest = ~reset_reset_n | full;
`endif

  // Byte-lane write into memory at the accept edge.
  always_ff @(posedge clk_clk) begin
    if (wr_acc) begin
      for (int i = 0; i < 4; i++) begin
        if (avs_byteenable[i]) mem[widx][8*i +: 8] <= avs_writedata[8*i +: 8];
      end
    end
  end

  // Read pipeline: data moves only with a valid token, so the last stage
  // keeps the most recently returned word while idle.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pv <= '0;
      for (int i = 0; i < READ_LAT; i++) pd[i] <= '0;
    end else begin
      pv[0] <= rd_acc;
      if (rd_acc) pd[0] <= mem[widx];
      for (int i = 1; i < READ_LAT; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) pd[i] <= pd[i-1];
      end
    end
  end

  // Outstanding read counter.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pending <= '0;
    end else begin
      case ({rd_acc, ret})
        2'b10:   pending <= pending + 3'd1;
        2'b01:   pending <= pending - 3'd1;
        default: pending <= pending;
      endcase
    end
  end

  // Sticky flag for simultaneous read+write.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) err_sticky <= 1'b0;
    else if (wr_acc && avs_read) err_sticky <= 1'b1;
  end

  assign avs_readdatavalid = pv[READ_LAT-1];
  assign avs_readdata      = pd[READ_LAT-1];

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Bench for avalon_mem_responder (default parameters, no wait-state macro).
// Driver tasks push expected read data and accept time into queues; a
// negedge monitor pops and compares whenever avs_readdatavalid is seen.
module tb_avalon_mem_responder;
  localparam int MEM_AW   = 10;
  localparam int READ_LAT = 2;
  localparam int MAX_PEND = 2;
  localparam int WAIT_CYC = 2;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [31:0] avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [3:0]  avs_byteenable = '0;
  logic [31:0] avs_writedata = '0;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        err_sticky;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  time         t_q[$];
  logic [31:0] last_exp = '0;

  avalon_mem_responder #(
    .MEM_AW(MEM_AW), .READ_LAT(READ_LAT), .MAX_PEND(MAX_PEND), .WAIT_CYC(WAIT_CYC)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset_n(reset_reset_n),
    .avs_address(avs_address),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_byteenable(avs_byteenable),
    .avs_writedata(avs_writedata),
    .avs_waitrequest(avs_waitrequest),
    .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .err_sticky(err_sticky)
  );

  // clock: posedges at 5, 15, 25 ...
  always #5 clk_clk = ~clk_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk_clk) begin
    if (!reset_reset_n) begin
      exp_q.delete();
      t_q.delete();
      last_exp = '0;
    end else if (avs_readdatavalid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: readdata 0x%08h with no read outstanding at %0t",
                 avs_readdata, $time);
      end else begin
        logic [31:0] e;
        time         ta;
        e  = exp_q.pop_front();
        ta = t_q.pop_front();
        check("read_data", avs_readdata, e);
        check("read_latency", 32'($time - ta), 32'((READ_LAT - 1) * 10 + 5));
        last_exp = e;
      end
    end else begin
      check("readdata_hold", avs_readdata, last_exp);
    end
  end

  // Issue one command at a negedge; returns at the negedge after accept.
  task automatic do_cmd(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] data,
                        input logic [31:0] exp, output int stalls,
                        output logic first_wait);
    avs_read       = rd;
    avs_write      = wr;
    avs_address    = addr;
    avs_byteenable = be;
    avs_writedata  = data;
    stalls = 0;
    #1;
    first_wait = avs_waitrequest;
    while (avs_waitrequest && stalls < 20) begin
      @(negedge clk_clk);
      #1;
      stalls++;
    end
    if (avs_waitrequest) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: waitrequest stuck at 1 for %0d cycles", stalls);
    end
    @(posedge clk_clk);
    if (rd && !wr) begin
      exp_q.push_back(exp);
      t_q.push_back($time);
    end
    @(negedge clk_clk);
  endtask

  task automatic idle();
    avs_read  = 1'b0;
    avs_write = 1'b0;
  endtask

  task automatic wr_cmd(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    int s;
    logic fw;
    do_cmd(1'b0, 1'b1, addr, be, data, '0, s, fw);
    idle();
  endtask

  task automatic rd_cmd(input logic [31:0] addr, input logic [31:0] exp);
    int s;
    logic fw;
    do_cmd(1'b1, 1'b0, addr, 4'hf, '0, exp, s, fw);
    idle();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d responses still outstanding", exp_q.size());
    end
    repeat (2) @(negedge clk_clk);
  endtask

  initial begin
    int   s [4];
    logic fw [4];

    // reset state
    repeat (3) @(negedge clk_clk);
    check("rst_waitrequest", 32'(avs_waitrequest), 32'd1);
    check("rst_valid", 32'(avs_readdatavalid), 32'd0);
    check("rst_readdata", avs_readdata, 32'd0);
    check("rst_err", 32'(err_sticky), 32'd0);
    #2 reset_reset_n = 1'b1;
    #1 check("post_rst_waitrequest", 32'(avs_waitrequest), 32'd0);
    @(negedge clk_clk);

    // partial byte-enable write over a known word
    wr_cmd(32'h0000_0008, 4'b1111, 32'h0000_0000);
    wr_cmd(32'h0000_0008, 4'b0111, 32'hDEAD_0008);
    rd_cmd(32'h0000_0008, 32'h00AD_0008);
    // byteenable 0000 leaves memory unchanged
    wr_cmd(32'h0000_0008, 4'b0000, 32'hFFFF_FFFF);
    rd_cmd(32'h0000_0008, 32'h00AD_0008);
    drain();

    // address aliasing and ignored low bits
    wr_cmd(32'h0000_1000, 4'b1111, 32'h1234_5678);
    rd_cmd(32'h0000_0000, 32'h1234_5678);
    rd_cmd(32'h0000_0003, 32'h1234_5678);
    rd_cmd(32'hFFFF_F000, 32'h1234_5678);
    drain();

    // mixed lanes
    wr_cmd(32'h0000_0010, 4'b1111, 32'hAABB_CCDD);
    wr_cmd(32'h0000_0010, 4'b1010, 32'h1122_3344);
    rd_cmd(32'h0000_0010, 32'h11BB_33DD);
    drain();

    // read+write together: write only, no response, sticky error
    do_cmd(1'b1, 1'b1, 32'h0000_0004, 4'b1111, 32'hCAFE_F00D, '0, s[0], fw[0]);
    idle();
    check("err_set", 32'(err_sticky), 32'd1);
    repeat (4) @(negedge clk_clk);
    check("err_held", 32'(err_sticky), 32'd1);
    rd_cmd(32'h0000_0004, 32'hCAFE_F00D);
    drain();

    // four back-to-back reads: third sees the pending limit
    do_cmd(1'b1, 1'b0, 32'h0000_0008, 4'hf, '0, 32'h00AD_0008, s[0], fw[0]);
    do_cmd(1'b1, 1'b0, 32'h0000_0000, 4'hf, '0, 32'h1234_5678, s[1], fw[1]);
    do_cmd(1'b1, 1'b0, 32'h0000_0004, 4'hf, '0, 32'hCAFE_F00D, s[2], fw[2]);
    do_cmd(1'b1, 1'b0, 32'h0000_0010, 4'hf, '0, 32'h11BB_33DD, s[3], fw[3]);
    idle();
    check("b2b_r1_wait", 32'(fw[0]), 32'd0);
    check("b2b_r2_wait", 32'(fw[1]), 32'd0);
    check("b2b_r3_wait", 32'(fw[2]), 32'd1);
    check("b2b_r3_stalls", 32'(s[2]), 32'd1);
    check("b2b_r4_stalls", 32'(s[3]), 32'd0);
    drain();

    // reset one cycle after a read accept discards it
    rd_cmd(32'h0000_0000, 32'h1234_5678);
    #2 reset_reset_n = 1'b0;
    #1 check("mid_rst_waitrequest", 32'(avs_waitrequest), 32'd1);
    check("mid_rst_valid", 32'(avs_readdatavalid), 32'd0);
    check("mid_rst_readdata", avs_readdata, 32'd0);
    check("mid_rst_err", 32'(err_sticky), 32'd0);
    repeat (3) @(negedge clk_clk);
    #1 check("mid_rst_waitrequest_hold", 32'(avs_waitrequest), 32'd1);
    #1 reset_reset_n = 1'b1;
    #1 check("rerst_waitrequest", 32'(avs_waitrequest), 32'd0);
    repeat (8) @(negedge clk_clk);
    // memory survives reset
    rd_cmd(32'h0000_0010, 32'h11BB_33DD);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
